mem_byte_ctrl: RTL and testbench

//  Memory controller between the CPU pipeline and the 8-bit RAM/IO bus.

---
 rtl/mem_byte_ctrl_pkg.sv | 40 ++++
 rtl/mem_byte_ctrl_if.sv | 38 +++
 rtl/mem_byte_ctrl_lane.sv | 34 +++
 rtl/mem_byte_ctrl.sv | 146 ++++++++++++++
 tb/tb_mem_byte_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_byte_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller:
// transfer sizes, FSM states, requester identity and the IO region select.
package mem_byte_ctrl_pkg;

   localparam int         ADDR_W = 32;
   localparam logic [1:0] IO_SEL = 2'b11;

   typedef enum logic [1:0] {
      SZ_BYTE     = 2'b00,
      SZ_HALF     = 2'b01,
      SZ_WORD     = 2'b10,
      SZ_WORD_ALT = 2'b11
   } mem_size_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_DONE
   } state_e;

   typedef enum logic {
      OWN_IF,
      OWN_MEM
   } owner_e;

   // The reserved encoding 11 falls through to a full word.
   function automatic logic [2:0] size_to_count(input mem_size_e size);
      case (size)
         SZ_BYTE: return 3'd1;
         SZ_HALF: return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic is_io(input logic [1:0] region);
      return region == IO_SEL;
   endfunction

endpackage

// File: rtl/mem_byte_ctrl_if.sv
// CPU-side request/response signals plus the 8-bit RAM/IO bus of the
// byte-serial memory controller.
interface mem_byte_ctrl_if;
   import mem_byte_ctrl_pkg::*;

   logic              if_req_i;
   logic [ADDR_W-1:0] if_addr_i;
   logic              if_flush_i;
   logic              mem_req_i;
   logic              mem_we_i;
   logic [1:0]        mem_size_i;
   logic [ADDR_W-1:0] mem_addr_i;
   logic [31:0]       mem_wdata_i;
   logic [7:0]        mem_din;
   logic [ADDR_W-1:0] mem_a;
   logic [7:0]        mem_dout;
   logic              mem_wr;
   logic [31:0]       rdata_o;
   logic              if_done_o;
   logic              mem_done_o;
   logic              if_stall_o;
   logic              mem_stall_o;

   modport master (
      output if_req_i, if_addr_i, if_flush_i, mem_req_i, mem_we_i, mem_size_i,
             mem_addr_i, mem_wdata_i, mem_din,
      input  mem_a, mem_dout, mem_wr, rdata_o, if_done_o, mem_done_o,
             if_stall_o, mem_stall_o
   );

   modport slave (
      input  if_req_i, if_addr_i, if_flush_i, mem_req_i, mem_we_i, mem_size_i,
             mem_addr_i, mem_wdata_i, mem_din,
      output mem_a, mem_dout, mem_wr, rdata_o, if_done_o, mem_done_o,
             if_stall_o, mem_stall_o
   );

endinterface

// File: rtl/mem_byte_ctrl_lane.sv
// Read-data assembler: drops each returned byte into its little-endian lane
// of a 32-bit register; clearing keeps unused upper bytes at zero.
module mem_byte_lane (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        cap_en,
   input  logic [1:0]  lane,
   input  logic [7:0]  din,
   output logic [31:0] data
);

   logic [31:0] data_q, data_d;

   always_comb begin
      data_d = data_q;
      if (clear) begin
         data_d = '0;
      end else if (cap_en) begin
         data_d[{lane, 3'b000} +: 8] = din;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign data = data_q;

endmodule

// File: rtl/mem_byte_ctrl.sv
// Byte-serial memory controller: arbitrates instruction fetches and data
// loads/stores onto an 8-bit RAM/IO bus and reassembles 32-bit read data.
module mem_byte_ctrl
   import mem_byte_ctrl_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           rdy,
   mem_byte_ctrl_if.slave bus
);

   state_e            state_q, state_d;
   owner_e            owner_q, owner_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [2:0]        count_q, count_d;
   logic [2:0]        issue_ptr_q, issue_ptr_d;
   logic [2:0]        cap_cnt_q, cap_cnt_d;
   logic [1:0]        cap_lane_q, cap_lane_d;
   logic              issued_q, issued_d;
   logic              issue_now;
   logic              capture_now;
   logic              clear_rdata;
   logic              flush_hit;
   logic [2:0]        cap_total;

   // A byte returns one cycle after its address; it is taken even while rdy is low.
   assign capture_now = issued_q && (state_q == S_READ);
   assign cap_total   = cap_cnt_q + {2'b00, capture_now};
   assign flush_hit   = (owner_q == OWN_IF) && bus.if_flush_i;
   assign issued_d    = issue_now;

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      base_d      = base_q;
      wdata_d     = wdata_q;
      count_d     = count_q;
      issue_ptr_d = issue_ptr_q;
      cap_cnt_d   = cap_cnt_q;
      cap_lane_d  = cap_lane_q;
      issue_now   = 1'b0;
      clear_rdata = 1'b0;
      bus.mem_a    = '0;
      bus.mem_dout = '0;
      bus.mem_wr   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (rdy) begin
               if (bus.mem_req_i) begin
                  owner_d     = OWN_MEM;
                  base_d      = bus.mem_addr_i;
                  wdata_d     = bus.mem_wdata_i;
                  count_d     = size_to_count(mem_size_e'(bus.mem_size_i));
                  issue_ptr_d = '0;
                  cap_cnt_d   = '0;
                  clear_rdata = 1'b1;
                  state_d     = bus.mem_we_i ? S_WRITE : S_READ;
               end else if (bus.if_req_i && !bus.if_flush_i) begin
                  owner_d     = OWN_IF;
                  base_d      = bus.if_addr_i;
                  count_d     = 3'd4;
                  issue_ptr_d = '0;
                  cap_cnt_d   = '0;
                  clear_rdata = 1'b1;
                  state_d     = S_READ;
               end
            end
         end

         S_READ: begin
            if (rdy && (issue_ptr_q < count_q)) begin
               issue_now   = 1'b1;
               bus.mem_a   = base_q + ADDR_W'(issue_ptr_q);
               cap_lane_d  = issue_ptr_q[1:0];
               issue_ptr_d = issue_ptr_q + 3'd1;
            end
            cap_cnt_d = cap_total;
            if (rdy && (cap_total == count_q)) begin
               state_d = S_DONE;
            end
            if (flush_hit) begin
               state_d = S_IDLE;
            end
         end

         S_WRITE: begin
            if (rdy) begin
               bus.mem_wr   = 1'b1;
               bus.mem_a    = base_q + ADDR_W'(issue_ptr_q);
               bus.mem_dout = wdata_q[{issue_ptr_q[1:0], 3'b000} +: 8];
               issue_ptr_d  = issue_ptr_q + 3'd1;
               if (issue_ptr_q == (count_q - 3'd1)) begin
                  state_d = S_DONE;
               end
            end
         end

         // Leaves unconditionally so the done pulse is always exactly one cycle.
         S_DONE: state_d = S_IDLE;

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         owner_q     <= OWN_IF;
         base_q      <= '0;
         wdata_q     <= '0;
         count_q     <= '0;
         issue_ptr_q <= '0;
         cap_cnt_q   <= '0;
         cap_lane_q  <= '0;
         issued_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         base_q      <= base_d;
         wdata_q     <= wdata_d;
         count_q     <= count_d;
         issue_ptr_q <= issue_ptr_d;
         cap_cnt_q   <= cap_cnt_d;
         cap_lane_q  <= cap_lane_d;
         issued_q    <= issued_d;
      end
   end

   mem_byte_lane u_lane (
      .clk    (clk),
      .rst    (rst),
      .clear  (clear_rdata),
      .cap_en (capture_now),
      .lane   (cap_lane_q),
      .din    (bus.mem_din),
      .data   (bus.rdata_o)
   );

   assign bus.if_done_o   = (state_q == S_DONE) && (owner_q == OWN_IF) && !bus.if_flush_i;
   assign bus.mem_done_o  = (state_q == S_DONE) && (owner_q == OWN_MEM);
   assign bus.if_stall_o  = bus.if_req_i && !bus.if_done_o;
   assign bus.mem_stall_o = bus.mem_req_i && !bus.mem_done_o;

endmodule

// File: tb/tb_mem_byte_ctrl.sv
// Directed bench for mem_byte_ctrl: a byte RAM model answers the bus, and
// queues of expected reads, writes and done events are checked every cycle.
module tb_mem_byte_ctrl;
   import mem_byte_ctrl_pkg::*;

   typedef struct {
      bit          is_if;
      bit          chk;
      logic [31:0] rdata;
   } done_t;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  data;
   } wr_t;

   logic clk = 1'b0;
   logic rst;
   logic rdy;
   int   checks = 0;
   int   errors = 0;
   int   wr_count = 0;

   logic [7:0]  ram [logic [31:0]];
   logic [31:0] last_a = '0;
   logic [31:0] exp_reads[$];
   wr_t         exp_writes[$];
   done_t       exp_done[$];
   done_t       cur_done;
   wr_t         cur_wr;
   logic [31:0] cur_rd;

   mem_byte_ctrl_if bus();

   mem_byte_ctrl dut (
      .clk (clk),
      .rst (rst),
      .rdy (rdy),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] ramRead(input logic [31:0] a);
      if (ram.exists(a)) return ram[a];
      return 8'h00;
   endfunction

   // Little-endian, zero-extended value of n bytes starting at addr.
   function automatic logic [31:0] modelRead(input logic [31:0] addr, input int n);
      logic [31:0] v = '0;
      for (int i = 0; i < n; i++) v = v | (32'(ramRead(addr + 32'(i))) << (8 * i));
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input bit is_if, input bit we, input logic [1:0] size,
                                input logic [31:0] addr, input logic [31:0] wdata);
      if (is_if) begin
         bus.if_req_i  = 1'b1;
         bus.if_addr_i = addr;
      end else begin
         bus.mem_req_i   = 1'b1;
         bus.mem_we_i    = we;
         bus.mem_size_i  = size;
         bus.mem_addr_i  = addr;
         bus.mem_wdata_i = wdata;
      end
   endtask

   task automatic expectRead(input bit is_if, input logic [31:0] addr, input int n);
      done_t d;
      for (int i = 0; i < n; i++) exp_reads.push_back(addr + 32'(i));
      d.is_if = is_if;
      d.chk   = 1'b1;
      d.rdata = modelRead(addr, n);
      exp_done.push_back(d);
   endtask

   task automatic expectStore(input logic [31:0] addr, input logic [31:0] wdata, input int n);
      done_t d;
      wr_t   w;
      for (int i = 0; i < n; i++) begin
         w.addr = addr + 32'(i);
         w.data = wdata[8*i +: 8];
         exp_writes.push_back(w);
      end
      d.is_if = 1'b0;
      d.chk   = 1'b0;
      d.rdata = '0;
      exp_done.push_back(d);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns k when the requested done is seen in the k-th cycle after the call.
   task automatic waitDone(input bit want_if, input int budget, output int cycles);
      cycles = 0;
      forever begin
         @(negedge clk);
         if (want_if ? bus.if_done_o : bus.mem_done_o) break;
         if (cycles >= budget) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: got no done after %0d cycles, expected done (if=%0b)", cycles, want_if);
            break;
         end
         tick();
         cycles++;
      end
   endtask

   // RAM/IO responder: data for the address seen this cycle appears next cycle.
   always @(negedge clk) begin
      last_a = bus.mem_a;
      if (rst && bus.mem_wr) ram[bus.mem_a] = bus.mem_dout;
   end

   always @(posedge clk) begin
      #1;
      bus.mem_din = ramRead(last_a);
   end

   always @(negedge clk) begin
      if (rst) begin
         checkOutput("if_stall", 32'(bus.if_stall_o), 32'(bus.if_req_i && !bus.if_done_o));
         checkOutput("mem_stall", 32'(bus.mem_stall_o), 32'(bus.mem_req_i && !bus.mem_done_o));
         if (!rdy) begin
            checkOutput("park_mem_a", bus.mem_a, 32'h0);
            checkOutput("park_mem_wr", 32'(bus.mem_wr), 32'h0);
         end
         if (bus.mem_wr) begin
            wr_count++;
            if (exp_writes.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_write: got write 0x%02h at 0x%08h, expected none", bus.mem_dout, bus.mem_a);
            end else begin
               cur_wr = exp_writes.pop_front();
               checkOutput("write_addr", bus.mem_a, cur_wr.addr);
               checkOutput("write_data", 32'(bus.mem_dout), 32'(cur_wr.data));
            end
         end else if (rdy && bus.mem_a != 32'h0) begin
            if (exp_reads.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_read: got read at 0x%08h, expected none", bus.mem_a);
            end else begin
               cur_rd = exp_reads.pop_front();
               checkOutput("read_addr", bus.mem_a, cur_rd);
            end
         end
         if (bus.if_done_o || bus.mem_done_o) begin
            if (exp_done.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_done: got if_done=%0b mem_done=%0b, expected none", bus.if_done_o, bus.mem_done_o);
            end else begin
               cur_done = exp_done.pop_front();
               checkOutput("done_owner_if", 32'(bus.if_done_o), 32'(cur_done.is_if));
               checkOutput("done_owner_mem", 32'(bus.mem_done_o), 32'(!cur_done.is_if));
               if (cur_done.chk) checkOutput("done_rdata", bus.rdata_o, cur_done.rdata);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish by 200000, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lat;
      int wr0;
      rst = 1'b0;
      rdy = 1'b1;
      bus.if_req_i = 1'b0;   bus.if_addr_i = '0;  bus.if_flush_i = 1'b0;
      bus.mem_req_i = 1'b0;  bus.mem_we_i = 1'b0; bus.mem_size_i = 2'b00;
      bus.mem_addr_i = '0;   bus.mem_wdata_i = '0; bus.mem_din = '0;
      ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
      ram[32'h104] = 8'h93; ram[32'h105] = 8'h00; ram[32'h106] = 8'h10; ram[32'h107] = 8'h00;
      ram[32'h202] = 8'hFE; ram[32'h203] = 8'hFF;
      ram[32'h300] = 8'h01; ram[32'h301] = 8'h02; ram[32'h302] = 8'h03; ram[32'h303] = 8'h04;
      ram[32'h400] = 8'hB7; ram[32'h401] = 8'h12; ram[32'h402] = 8'h34; ram[32'h403] = 8'h00;
      ram[32'h600] = 8'h78; ram[32'h601] = 8'h56; ram[32'h602] = 8'h34; ram[32'h603] = 8'h12;

      #2;
      checkOutput("reset_mem_a", bus.mem_a, 32'h0);
      checkOutput("reset_mem_wr", 32'(bus.mem_wr), 32'h0);
      checkOutput("reset_mem_dout", 32'(bus.mem_dout), 32'h0);
      checkOutput("reset_rdata", bus.rdata_o, 32'h0);
      checkOutput("reset_if_done", 32'(bus.if_done_o), 32'h0);
      checkOutput("reset_mem_done", 32'(bus.mem_done_o), 32'h0);
      tick();
      tick();
      rst = 1'b1;
      tick();

      $display("[TB] fetch from 0x100");
      expectRead(1'b1, 32'h100, 4);
      applyStimulus(1'b1, 1'b0, 2'b10, 32'h100, 32'h0);
      waitDone(1'b1, 20, lat);
      checkOutput("t1_latency", 32'(lat), 32'd6);
      checkOutput("t1_rdata", bus.rdata_o, 32'h0000_0513);
      tick();
      bus.if_req_i = 1'b0;
      tick();

      $display("[TB] simultaneous IO byte store and fetch");
      wr0 = wr_count;
      expectStore(32'h0003_0000, 32'h0000_00AB, 1);
      expectRead(1'b1, 32'h104, 4);
      applyStimulus(1'b0, 1'b1, 2'b00, 32'h0003_0000, 32'h0000_00AB);
      applyStimulus(1'b1, 1'b0, 2'b10, 32'h104, 32'h0);
      waitDone(1'b0, 20, lat);
      checkOutput("t2_store_latency", 32'(lat), 32'd2);
      checkOutput("t2_single_write", 32'(wr_count - wr0), 32'd1);
      tick();
      bus.mem_req_i = 1'b0;
      waitDone(1'b1, 20, lat);
      checkOutput("t2_fetch_after_store", 32'(lat), 32'd6);
      checkOutput("t2_rdata", bus.rdata_o, 32'h0010_0093);
      tick();
      bus.if_req_i = 1'b0;
      tick();

      $display("[TB] lh from 0x202 with rdy low for 3 cycles");
      wr0 = wr_count;
      expectRead(1'b0, 32'h202, 2);
      applyStimulus(1'b0, 1'b0, 2'b01, 32'h202, 32'h0);
      tick();
      tick();
      rdy = 1'b0;
      tick();
      tick();
      tick();
      rdy = 1'b1;
      waitDone(1'b0, 20, lat);
      checkOutput("t3_latency", 32'(lat + 5), 32'd7);
      checkOutput("t3_rdata", bus.rdata_o, 32'h0000_FFFE);
      checkOutput("t3_no_writes", 32'(wr_count - wr0), 32'd0);
      tick();
      bus.mem_req_i = 1'b0;
      tick();

      $display("[TB] fetch flushed during third byte");
      exp_reads.push_back(32'h300);
      exp_reads.push_back(32'h301);
      exp_reads.push_back(32'h302);
      expectRead(1'b1, 32'h400, 4);
      applyStimulus(1'b1, 1'b0, 2'b10, 32'h300, 32'h0);
      tick();
      tick();
      tick();
      bus.if_flush_i = 1'b1;
      bus.if_addr_i  = 32'h400;
      tick();
      bus.if_flush_i = 1'b0;
      #2;
      checkOutput("t4_idle_after_flush", bus.mem_a, 32'h0);
      checkOutput("t4_no_done", 32'(bus.if_done_o), 32'h0);
      waitDone(1'b1, 20, lat);
      checkOutput("t4_refetch_latency", 32'(lat), 32'd6);
      checkOutput("t4_rdata", bus.rdata_o, 32'h0034_12B7);
      tick();
      bus.if_req_i = 1'b0;
      tick();

      $display("[TB] reset in the middle of a word store");
      exp_writes.push_back('{addr: 32'h500, data: 8'hEF});
      exp_writes.push_back('{addr: 32'h501, data: 8'hBE});
      applyStimulus(1'b0, 1'b1, 2'b10, 32'h500, 32'hDEAD_BEEF);
      tick();
      tick();
      tick();
      rst = 1'b0;
      #1;
      checkOutput("t5_wr_drops", 32'(bus.mem_wr), 32'h0);
      checkOutput("t5_addr_drops", bus.mem_a, 32'h0);
      bus.mem_req_i = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      @(negedge clk);
      checkOutput("t5_idle_addr", bus.mem_a, 32'h0);
      checkOutput("t5_rdata_cleared", bus.rdata_o, 32'h0);
      tick();
      expectRead(1'b0, 32'h600, 4);
      applyStimulus(1'b0, 1'b0, 2'b10, 32'h600, 32'h0);
      waitDone(1'b0, 20, lat);
      checkOutput("t5_lw_latency", 32'(lat), 32'd6);
      checkOutput("t5_lw_rdata", bus.rdata_o, 32'h1234_5678);
      tick();
      bus.mem_req_i = 1'b0;
      tick();

      $display("[TB] word store wrapping past the top of the address space");
      expectStore(32'hFFFF_FFFE, 32'h1122_3344, 4);
      applyStimulus(1'b0, 1'b1, 2'b10, 32'hFFFF_FFFE, 32'h1122_3344);
      waitDone(1'b0, 20, lat);
      checkOutput("t6_latency", 32'(lat), 32'd5);
      tick();
      bus.mem_req_i = 1'b0;
      tick();
      expectRead(1'b0, 32'hFFFF_FFFF, 1);
      applyStimulus(1'b0, 1'b0, 2'b00, 32'hFFFF_FFFF, 32'h0);
      waitDone(1'b0, 20, lat);
      checkOutput("t6_lb_latency", 32'(lat), 32'd3);
      checkOutput("t6_lb_rdata", bus.rdata_o, 32'h0000_0033);
      tick();
      bus.mem_req_i = 1'b0;
      tick();
      tick();

      checkOutput("left_reads", 32'(exp_reads.size()), 32'd0);
      checkOutput("left_writes", 32'(exp_writes.size()), 32'd0);
      checkOutput("left_dones", 32'(exp_done.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
